// File: rtl/io_mmio_controller.sv
// rtl/io_mmio_controller.sv - MMIO responder with compare timer, interrupt and byte TX FIFO
// Accesses are captured on acceptance and complete with a one-cycle ready pulse after a fixed latency.
module io_mmio_controller #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] m_a,
  input  logic [31:0] m_d_w,
  input  logic        io_access,
  input  logic        io_write,
  output logic [31:0] io_d_r,
  output logic        io_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic        irq
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_ctr;
  logic [2:0]    r_addr;
  logic [31:0]   r_wdata;
  logic          r_write;

  logic [31:0]   r_cnt, r_cmp;
  logic          r_en, r_ie, r_pend, r_ovf;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PW:0]   r_count;

  logic          w_done, w_commit;
  logic          w_wr_cnt, w_wr_cmp, w_wr_ctrl, w_wr_status, w_wr_tx;
  logic          w_match, w_empty, w_full, w_pop, w_push, w_drop;
  logic [31:0]   w_status, w_rdata;
  logic          w_unused;

  assign w_unused = ^{m_a[31:5], m_a[1:0]};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_access) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_ctr == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The captured copy is what completes, even if the master drops io_access.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ctr   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (r_state == S_IDLE && io_access) begin
      r_ctr   <= CW'(LATENCY - 1);
      r_addr  <= m_a[4:2];
      r_wdata <= m_d_w;
      r_write <= io_write;
    end else if (r_state == S_WAIT && r_ctr != '0) begin
      r_ctr <= r_ctr - CW'(1);
    end
  end

  assign w_done      = (r_state == S_DONE);
  assign w_commit    = w_done & r_write;
  assign w_wr_cnt    = w_commit & (r_addr == 3'd0);
  assign w_wr_cmp    = w_commit & (r_addr == 3'd1);
  assign w_wr_ctrl   = w_commit & (r_addr == 3'd2);
  assign w_wr_status = w_commit & (r_addr == 3'd3);
  assign w_wr_tx     = w_commit & (r_addr == 3'd4);
  assign w_match     = r_en & (r_cnt == r_cmp);

  // A CNT write beats the timer update; a new match beats a pend clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt  <= '0;
      r_cmp  <= '1;
      r_en   <= 1'b0;
      r_ie   <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_wr_cnt)     r_cnt <= r_wdata;
      else if (w_match) r_cnt <= '0;
      else if (r_en)    r_cnt <= r_cnt + 32'd1;
      if (w_wr_cmp) r_cmp <= r_wdata;
      if (w_wr_ctrl) begin
        r_en <= r_wdata[0];
        r_ie <= r_wdata[1];
      end
      if (w_match && !w_wr_cnt)           r_pend <= 1'b1;
      else if (w_wr_status && r_wdata[0]) r_pend <= 1'b0;
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & tx_ack;
  assign w_push  = w_wr_tx & (~w_full | w_pop);
  assign w_drop  = w_wr_tx & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_wdata[7:0];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
      if (w_drop)                         r_ovf <= 1'b1;
      else if (w_wr_status && r_wdata[3]) r_ovf <= 1'b0;
    end
  end

  assign w_status = {16'd0, 8'(r_count), 4'd0, r_ovf, w_empty, w_full, r_pend};

  always_comb begin
    w_rdata = '0;
    case (r_addr)
      3'd0:    w_rdata = r_cnt;
      3'd1:    w_rdata = r_cmp;
      3'd2:    w_rdata = {30'd0, r_ie, r_en};
      3'd3:    w_rdata = w_status;
      default: w_rdata = '0;
    endcase
  end

  assign io_ready = w_done;
  assign io_d_r   = (w_done && !r_write) ? w_rdata : 32'd0;
  assign tx_valid = ~w_empty;
  assign tx_data  = w_empty ? 8'd0 : r_mem[r_rd_ptr];
  assign irq      = r_pend & r_ie;

endmodule

// File: tb/tb_io_mmio_controller.sv
// tb/tb_io_mmio_controller.sv - randomized bench for io_mmio_controller against a behavioural model
module tb_io_mmio_controller;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 8;

  logic        clk;
  logic        clrn;
  logic [31:0] m_a;
  logic [31:0] m_d_w;
  logic        io_access;
  logic        io_write;
  logic [31:0] io_d_r;
  logic        io_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ack;
  logic        irq;

  io_mmio_controller #(.LATENCY(LATENCY), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clrn(clrn), .m_a(m_a), .m_d_w(m_d_w),
    .io_access(io_access), .io_write(io_write), .io_d_r(io_d_r), .io_ready(io_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] mdl_cnt, mdl_cmp, mdl_wdata;
  logic        mdl_en, mdl_ie, mdl_pend, mdl_ovf, mdl_busy, mdl_write;
  logic [7:0]  mdl_q[$];
  int          mdl_cyc = 0;
  int          mdl_done_at = 0;
  int          mdl_addr = 0;

  logic [31:0] rd;
  int          lat;
  logic [7:0]  got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_cnt = 32'd0; mdl_cmp = 32'hffffffff; mdl_en = 1'b0; mdl_ie = 1'b0;
    mdl_pend = 1'b0; mdl_ovf = 1'b0; mdl_busy = 1'b0; mdl_write = 1'b0;
    mdl_wdata = 32'd0; mdl_addr = 0;
    mdl_q.delete();
  endtask

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0: return mdl_cnt;
      1: return mdl_cmp;
      2: return {30'd0, mdl_ie, mdl_en};
      3: return {16'd0, 8'(mdl_q.size()), 4'd0, mdl_ovf, mdl_q.size() == 0,
                 mdl_q.size() == DEPTH, mdl_pend};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic done, wr, match, n_pend;
    logic [31:0] n_cnt;
    logic [7:0] dummy;
    done  = mdl_busy && (mdl_cyc == mdl_done_at);
    wr    = done && mdl_write;
    match = mdl_en && (mdl_cnt == mdl_cmp);
    n_cnt = mdl_cnt;
    if (mdl_en) n_cnt = match ? 32'd0 : mdl_cnt + 32'd1;
    if (wr && mdl_addr == 0) n_cnt = mdl_wdata;
    n_pend = mdl_pend;
    if (wr && mdl_addr == 3 && mdl_wdata[0]) n_pend = 1'b0;
    if (match && !(wr && mdl_addr == 0)) n_pend = 1'b1;
    if (wr && mdl_addr == 1) mdl_cmp = mdl_wdata;
    if (wr && mdl_addr == 2) begin mdl_en = mdl_wdata[0]; mdl_ie = mdl_wdata[1]; end
    if (wr && mdl_addr == 3 && mdl_wdata[3]) mdl_ovf = 1'b0;
    if (mdl_q.size() > 0 && tx_ack) dummy = mdl_q.pop_front();
    if (wr && mdl_addr == 4) begin
      if (mdl_q.size() < DEPTH) mdl_q.push_back(mdl_wdata[7:0]);
      else mdl_ovf = 1'b1;
    end
    mdl_cnt  = n_cnt;
    mdl_pend = n_pend;
    if (done) mdl_busy = 1'b0;
    else if (!mdl_busy && io_access) begin
      mdl_busy    = 1'b1;
      mdl_addr    = int'((m_a >> 2) % 8);
      mdl_wdata   = m_d_w;
      mdl_write   = io_write;
      mdl_done_at = mdl_cyc + LATENCY + 1;
    end
    mdl_cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge clrn);
      if (!clrn) model_reset();
      else model_step();
    end
  end

  initial begin
    logic exp_ready;
    forever begin
      @(negedge clk);
      exp_ready = mdl_busy && (mdl_cyc == mdl_done_at);
      chk("io_ready", 32'(io_ready), 32'(exp_ready));
      chk("io_d_r", io_d_r, (exp_ready && !mdl_write) ? model_read(mdl_addr) : 32'd0);
      chk("tx_valid", 32'(tx_valid), 32'(mdl_q.size() > 0));
      chk("tx_data", 32'(tx_data), (mdl_q.size() > 0) ? 32'(mdl_q[0]) : 32'd0);
      chk("irq", 32'(irq), 32'(mdl_pend & mdl_ie));
    end
  end

  // ack_mode: 0 hold tx_ack, 1 randomize tx_ack, 2 raise tx_ack in the ready cycle
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                           input int ack_mode, input bit drop_early);
    logic seen;
    seen = 1'b0; rd = 32'd0; lat = -1;
    m_a = addr; m_d_w = wd; io_write = wr; io_access = 1'b1;
    @(posedge clk); #1;
    if (drop_early) begin
      io_access = 1'b0; m_a = $urandom(); m_d_w = $urandom(); io_write = 1'($urandom_range(0, 1));
    end
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (ack_mode == 1) tx_ack = 1'($urandom_range(0, 1));
      if (io_ready) begin
        seen = 1'b1; rd = io_d_r; lat = n;
        if (ack_mode == 2) tx_ack = 1'b1;
      end
    end
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(LATENCY + 1));
    @(posedge clk); #1;
    io_access = 1'b0;
    if (ack_mode == 2) tx_ack = 1'b0;
  endtask

  task automatic idle(input int n, input bit rand_ack);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (rand_ack) tx_ack = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(input int n);
    got.delete();
    tx_ack = 1'b1;
    for (int i = 0; i < 40 && got.size() < n; i++) begin
      @(negedge clk);
      if (tx_valid) got.push_back(tx_data);
    end
    @(posedge clk); #1;
    tx_ack = 1'b0;
    chk("drain_count", 32'(got.size()), 32'(n));
  endtask

  initial begin
    logic [31:0] a;
    clrn = 1'b0; m_a = 32'd0; m_d_w = 32'd0; io_access = 1'b0; io_write = 1'b0; tx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;

    // Read CMP after reset
    do_access(32'h4, 32'd0, 1'b0, 0, 0);
    chk("cmp_reset", rd, 32'hffffffff);

    // Timer match, interrupt, clear
    do_access(32'h4, 32'd5, 1'b1, 0, 0);
    do_access(32'h8, 32'd3, 1'b1, 0, 0);
    idle(12, 0);
    @(negedge clk); chk("irq_set", 32'(irq), 32'd1);
    @(posedge clk); #1;
    do_access(32'h8, 32'd2, 1'b1, 0, 0);
    do_access(32'hC, 32'd0, 1'b0, 0, 0);
    chk("pend_status", 32'(rd[0]), 32'd1);
    do_access(32'h0, 32'd0, 1'b0, 0, 0);
    chk("cnt_range", 32'(rd <= 32'd5), 32'd1);
    do_access(32'hC, 32'd1, 1'b1, 0, 0);
    @(negedge clk); chk("irq_clear", 32'(irq), 32'd0);
    @(posedge clk); #1;

    // FIFO fill, overflow, drain
    for (int i = 0; i < 8; i++) do_access(32'h10, 32'h10 + i, 1'b1, 0, 0);
    do_access(32'hC, 32'd0, 1'b0, 0, 0);
    chk("fifo_count8", 32'(rd[15:8]), 32'd8);
    chk("fifo_full", 32'(rd[1]), 32'd1);
    do_access(32'h10, 32'h99, 1'b1, 0, 0);
    do_access(32'hC, 32'd0, 1'b0, 0, 0);
    chk("fifo_ovf", 32'(rd[3]), 32'd1);
    chk("fifo_count_after_drop", 32'(rd[15:8]), 32'd8);
    drain(8);
    for (int i = 0; i < got.size(); i++) chk("drain_order", 32'(got[i]), 32'h10 + i);
    do_access(32'hC, 32'd8, 1'b1, 0, 0);
    do_access(32'hC, 32'd0, 1'b0, 0, 0);
    chk("ovf_cleared", 32'(rd[3]), 32'd0);
    chk("fifo_empty", 32'(rd[2]), 32'd1);

    // Push into full FIFO coinciding with a pop
    for (int i = 0; i < 8; i++) do_access(32'h10, 32'h20 + i, 1'b1, 0, 0);
    do_access(32'h10, 32'hA5, 1'b1, 2, 0);
    do_access(32'hC, 32'd0, 1'b0, 0, 0);
    chk("pushpop_count", 32'(rd[15:8]), 32'd8);
    chk("pushpop_no_ovf", 32'(rd[3]), 32'd0);
    drain(8);
    for (int i = 0; i < got.size(); i++)
      chk("pushpop_order", 32'(got[i]), (i == 7) ? 32'hA5 : 32'h21 + i);

    // Match coinciding with STATUS clear: set wins
    do_access(32'h8, 32'd0, 1'b1, 0, 0);
    do_access(32'h0, 32'd0, 1'b1, 0, 0);
    do_access(32'h4, 32'd3, 1'b1, 0, 0);
    do_access(32'hC, 32'd1, 1'b1, 0, 0);
    do_access(32'h8, 32'd1, 1'b1, 0, 0);
    do_access(32'hC, 32'd1, 1'b1, 0, 0);
    do_access(32'hC, 32'd0, 1'b0, 0, 0);
    chk("set_wins", 32'(rd[0]), 32'd1);
    do_access(32'h8, 32'd0, 1'b1, 0, 0);

    // CNT write coinciding with match: write wins, no pend
    do_access(32'h0, 32'd0, 1'b1, 0, 0);
    do_access(32'hC, 32'd1, 1'b1, 0, 0);
    do_access(32'h8, 32'd1, 1'b1, 0, 0);
    do_access(32'h0, 32'h77, 1'b1, 0, 0);
    do_access(32'h8, 32'd0, 1'b1, 0, 0);
    do_access(32'h0, 32'd0, 1'b0, 0, 0);
    chk("cnt_write_wins", rd, 32'h7b);
    do_access(32'hC, 32'd0, 1'b0, 0, 0);
    chk("no_pend_on_write", 32'(rd[0]), 32'd0);
    idle(5, 0);
    do_access(32'h0, 32'd0, 1'b0, 0, 0);
    chk("cnt_frozen", rd, 32'h7b);

    // 32-bit wrap without match
    do_access(32'h4, 32'h100, 1'b1, 0, 0);
    do_access(32'h0, 32'hfffffffd, 1'b1, 0, 0);
    do_access(32'h8, 32'd1, 1'b1, 0, 0);
    do_access(32'h8, 32'd0, 1'b1, 0, 0);
    do_access(32'h0, 32'd0, 1'b0, 0, 0);
    chk("cnt_wrapped", rd, 32'd1);
    do_access(32'hC, 32'd0, 1'b0, 0, 0);
    chk("wrap_no_pend", 32'(rd[0]), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      int sel;
      logic [31:0] d;
      sel = $urandom_range(0, 7);
      a = $urandom();
      a[4:2] = 3'(sel);
      d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom();
      do_access(a, d, 1'($urandom_range(0, 1)), 1, ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 3), 1);
    end
    tx_ack = 1'b0;

    // Reset during WAIT
    m_a = 32'h4; io_write = 1'b0; io_access = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clrn = 1'b0; io_access = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_io_ready", 32'(io_ready), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
    end
    @(posedge clk); #1;
    clrn = 1'b1;
    idle(2, 0);
    do_access(32'h4, 32'd0, 1'b0, 0, 0);
    chk("cmp_after_reset", rd, 32'hffffffff);
    idle(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
